// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, default timing and command decode for the LCD bus writer
package lcd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC, S_DONE} state_t;
  localparam int DEF_T_SETUP = 2;
  localparam int DEF_T_PULSE = 12;
  localparam int DEF_T_HOLD = 2;
  localparam int DEF_T_EXEC = 2000;
  localparam int DEF_T_EXEC_LONG = 82000;
  localparam int DEF_CNT_W = 17;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME = 8'h02;
  // Instruction codes 0x00-0x03 (clear, home) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && ((d | (CMD_CLEAR | CMD_HOME)) == (CMD_CLEAR | CMD_HOME));
  endfunction
endpackage

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter: loadable down counter timing each bus phase, with registered zero flag
//   Clk, Reset_n : clock, async active-low reset
//   load, val    : start a phase lasting val cycles (val >= 1); load wins over en
//   en           : count down one step
//   zero         : high during the last cycle of the loaded phase
module lcd_delay_counter #(
  parameter int CNT_W = 17
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  // Stores val-1 so that zero marks the final cycle and the FSM can leave on that edge.
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      cnt <= '0;
      zero <= 1'b1;
    end else if (load) begin
      cnt <= val - 1'b1;
      zero <= val == CNT_W'(1);
    end else if (en) begin
      cnt <= cnt - 1'b1;
      zero <= cnt == CNT_W'(1);
    end
endmodule

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: executes one HD44780 bus write per Ejecutar request and pulses Escrito
//   Clk, Reset_n          : clock, async active-low reset
//   Ejecutar, DataIn, RsIn: write request (level), byte, register select
//   LCD_E/RS/RW/DB        : registered LCD bus (RW tied 0)
//   Ocupado, Escrito      : busy flag, one-cycle completion pulse
//   LCD_4BIT_EN           : when defined, send each byte as two nibbles on LCD_DB[7:4]
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_HOLD = DEF_T_HOLD,
  parameter int T_EXEC = DEF_T_EXEC,
  parameter int T_EXEC_LONG = DEF_T_EXEC_LONG,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Ejecutar,
  input  logic [7:0] DataIn,
  input  logic       RsIn,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DB,
  output logic       Ocupado,
  output logic       Escrito
);
  if (T_SETUP < 1 || T_PULSE < 1 || T_HOLD < 1 || T_EXEC < 1 || T_EXEC_LONG < 1 ||
      (T_EXEC >> CNT_W) != 0 || (T_EXEC_LONG >> CNT_W) != 0) begin : g_bad_timing
    $error("lcd_bus_writer: timing parameters must be >= 1 and below 2**CNT_W");
  end
  state_t state, state_n;
  logic armed, exec_long, accept, ld, en, zero, last_nib;
  logic [CNT_W-1:0] ld_val;
`ifdef LCD_4BIT_EN
  logic nib;
  logic [3:0] lo_nib;
  assign last_nib = nib;
`else
  assign last_nib = 1'b1;
`endif
  assign accept = state == S_IDLE && Ejecutar && armed;
  assign en = state inside {S_SETUP, S_PULSE, S_HOLD, S_EXEC};
  assign LCD_RW = 1'b0;
  always_comb begin
    state_n = state;
    ld = 1'b0;
    ld_val = CNT_W'(T_SETUP);
    case (state)
      S_IDLE: if (accept) begin state_n = S_SETUP; ld = 1'b1; end
      S_SETUP: if (zero) begin state_n = S_PULSE; ld = 1'b1; ld_val = CNT_W'(T_PULSE); end
      S_PULSE: if (zero) begin state_n = S_HOLD; ld = 1'b1; ld_val = CNT_W'(T_HOLD); end
      S_HOLD: if (zero) begin
        // In nibble mode the first HOLD loops back to SETUP for the low nibble.
        state_n = last_nib ? S_EXEC : S_SETUP;
        ld = 1'b1;
        ld_val = !last_nib ? CNT_W'(T_SETUP) : exec_long ? CNT_W'(T_EXEC_LONG) : CNT_W'(T_EXEC);
      end
      S_EXEC: if (zero) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  lcd_delay_counter #(.CNT_W(CNT_W)) u_cnt (
    .Clk(Clk), .Reset_n(Reset_n), .load(ld), .en(en), .val(ld_val), .zero(zero)
  );
  // Outputs are registered from the current state, so E and Escrito trail the state by one cycle.
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= S_IDLE;
      armed <= 1'b1;
      exec_long <= 1'b0;
      LCD_E <= 1'b0;
      LCD_RS <= 1'b0;
      LCD_DB <= 8'h00;
      Ocupado <= 1'b0;
      Escrito <= 1'b0;
`ifdef LCD_4BIT_EN
      nib <= 1'b0;
      lo_nib <= 4'h0;
`endif
    end else begin
      state <= state_n;
      armed <= !Ejecutar || (armed && state != S_DONE);
      LCD_E <= state == S_PULSE;
      Ocupado <= state != S_IDLE;
      Escrito <= state == S_DONE;
      if (accept) begin
        LCD_RS <= RsIn;
        exec_long <= is_long_cmd(RsIn, DataIn);
`ifdef LCD_4BIT_EN
        LCD_DB <= {DataIn[7:4], 4'h0};
        lo_nib <= DataIn[3:0];
        nib <= 1'b0;
`else
        LCD_DB <= DataIn;
`endif
      end
`ifdef LCD_4BIT_EN
      if (state == S_HOLD && zero && !nib) begin
        nib <= 1'b1;
        LCD_DB <= {lo_nib, 4'h0};
      end
`endif
    end
endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb_lcd_bus_writer: directed checks of bus timing, latency, re-arm and async reset
module tb_lcd_bus_writer;
  localparam int TL = 5000;
`ifdef LCD_4BIT_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif
  localparam int LAT_S = NP * 16 + 2000 + 1;
  localparam int LAT_L = NP * 16 + TL + 1;
  logic Clk = 1'b0, Reset_n = 1'b0, Ejecutar = 1'b0, RsIn = 1'b0;
  logic [7:0] DataIn = 8'h00;
  logic LCD_E, LCD_RS, LCD_RW, Ocupado, Escrito;
  logic [7:0] LCD_DB;
  int checks = 0, errors = 0;
  int lat, e_first, e_cnt, pulses, bad, n;
  lcd_bus_writer #(.T_EXEC_LONG(TL)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Ejecutar(Ejecutar), .DataIn(DataIn), .RsIn(RsIn),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DB(LCD_DB),
    .Ocupado(Ocupado), .Escrito(Escrito)
  );
  always #5 Clk = ~Clk;
  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) exp %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask
  task automatic run_txn(input logic rs, input logic [7:0] d, input int drop_at, input bit keep,
                         output int lat_o, output int e_first_o, output int e_cnt_o,
                         output int pulses_o, output int bad_o);
    logic pe;
    @(negedge Clk);
    Ejecutar = 1'b1;
    RsIn = rs;
    DataIn = d;
    @(posedge Clk);
    lat_o = -1; e_first_o = -1; e_cnt_o = 0; pulses_o = 0; bad_o = 0; pe = 1'b0;
    for (int i = 1; i <= 20000 && lat_o < 0; i++) begin
      @(negedge Clk);
      if (i == drop_at) begin
        Ejecutar = 1'b0;
        DataIn = 8'hFF;
        RsIn = ~rs;
      end
      if (LCD_E && !pe) begin
        pulses_o++;
        if (e_first_o < 0) e_first_o = i - 1;
      end
      if (LCD_E) e_cnt_o++;
`ifdef LCD_4BIT_EN
      if (LCD_E && LCD_DB !== (pulses_o <= 1 ? {d[7:4], 4'h0} : {d[3:0], 4'h0})) bad_o++;
      if (LCD_DB[3:0] !== 4'h0) bad_o++;
`else
      if (LCD_DB !== d) bad_o++;
`endif
      if (LCD_RS !== rs || LCD_RW !== 1'b0) bad_o++;
      pe = LCD_E;
      if (Escrito) lat_o = i - 1;
    end
    if (!keep) Ejecutar = 1'b0;
  endtask
  initial begin
    #3;
    chk("rst_e", LCD_E, 0);
    chk("rst_ocupado", Ocupado, 0);
    chk("rst_escrito", Escrito, 0);
    chk("rst_db", LCD_DB, 0);
    chk("rst_rs", LCD_RS, 0);
    chk("rst_rw", LCD_RW, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    run_txn(1'b1, 8'h41, 0, 1'b0, lat, e_first, e_cnt, pulses, bad);
    chk("a_latency", lat, LAT_S);
    chk("a_e_start", e_first, 3);
    chk("a_e_cycles", e_cnt, NP * 12);
    chk("a_pulses", pulses, NP);
    chk("a_bus_bad", bad, 0);
    @(negedge Clk);
    chk("a_escrito_1cyc", Escrito, 0);
    chk("a_ocupado_after", Ocupado, 0);
`ifdef LCD_4BIT_EN
    chk("a_db_kept", LCD_DB, 8'h10);
`else
    chk("a_db_kept", LCD_DB, 8'h41);
`endif
    chk("a_rs_kept", LCD_RS, 1);
    run_txn(1'b0, 8'h01, 0, 1'b0, lat, e_first, e_cnt, pulses, bad);
    chk("clear_latency", lat, LAT_L);
    chk("clear_bus_bad", bad, 0);
    run_txn(1'b0, 8'h38, 0, 1'b0, lat, e_first, e_cnt, pulses, bad);
    chk("func_latency", lat, LAT_S);
    run_txn(1'b0, 8'h03, 0, 1'b0, lat, e_first, e_cnt, pulses, bad);
    chk("code03_latency", lat, LAT_L);
    run_txn(1'b0, 8'h04, 0, 1'b0, lat, e_first, e_cnt, pulses, bad);
    chk("code04_latency", lat, LAT_S);
    run_txn(1'b1, 8'h02, 0, 1'b0, lat, e_first, e_cnt, pulses, bad);
    chk("data02_latency", lat, LAT_S);
    run_txn(1'b0, 8'h80, 0, 1'b1, lat, e_first, e_cnt, pulses, bad);
    chk("held_latency", lat, LAT_S);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (Ocupado || LCD_E || Escrito) n++;
    end
    chk("held_no_rewrite", n, 0);
    Ejecutar = 1'b0;
    @(negedge Clk);
    run_txn(1'b0, 8'h0C, 0, 1'b1, lat, e_first, e_cnt, pulses, bad);
    chk("rearm_latency", lat, LAT_S);
    chk("rearm_bus_bad", bad, 0);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (Ocupado) n++;
    end
    chk("rearm_single", n, 0);
    Ejecutar = 1'b0;
    @(negedge Clk);
    run_txn(1'b1, 8'h5A, 5, 1'b0, lat, e_first, e_cnt, pulses, bad);
    chk("drop_latency", lat, LAT_S);
    chk("drop_bus_bad", bad, 0);
    chk("drop_pulses", pulses, NP);
    @(negedge Clk);
    Ejecutar = 1'b1;
    RsIn = 1'b1;
    DataIn = 8'h33;
    n = 0;
    while (!LCD_E && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("mid_e_high", LCD_E, 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("mid_rst_e", LCD_E, 0);
    chk("mid_rst_ocupado", Ocupado, 0);
    chk("mid_rst_escrito", Escrito, 0);
    Ejecutar = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("post_rst_idle", Ocupado, 0);
    run_txn(1'b1, 8'hA5, 0, 1'b0, lat, e_first, e_cnt, pulses, bad);
    chk("post_rst_latency", lat, LAT_S);
    chk("post_rst_e_start", e_first, 3);
    chk("post_rst_bus_bad", bad, 0);
    chk("post_rst_pulses", pulses, NP);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
